ex_mem_stage: RTL and testbench

Memory stage of the 64-bit pipelined core, directly downstream of `execute`. It captures the execute-stage results (`aluResult_E`, `writeData_E`, `zero_E`, `PCBranch_E`) and control bits into the EX/MEM register. It runs loads and stores against the data memory over a req/ready handshake and stalls the upstream pipeline while an access is outstanding. It resolves conditional branches and presents a MEM/WB register to writeback.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_reg.sv | 20 ++
 rtl/ex_mem_stage.sv | 131 +++++++++++++
 tb/tb_ex_mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM/WB slice of the 64-bit pipelined core.
package pipe_pkg;

    localparam int N_DEFAULT = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [4:0]           rd;
        logic                 zero;
        logic [N_DEFAULT-1:0] pc_branch;
        logic [N_DEFAULT-1:0] alu_result;
        logic [N_DEFAULT-1:0] write_data;
    } exmem_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [4:0]           rd;
        logic [N_DEFAULT-1:0] alu_result;
        logic [N_DEFAULT-1:0] read_data;
    } memwb_t;

    function automatic logic is_mem_op(input logic valid, input logic rd_en, input logic wr_en);
        return valid & (rd_en | wr_en);
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with load enable and synchronous clear.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Memory stage: EX/MEM register, data-memory handshake FSM, branch resolve,
// and the MEM/WB register feeding writeback.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         Branch_E,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic [4:0]   rd_E,
    input  logic         zero_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic [N-1:0] dm_rdata,
    input  logic         dm_ready,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         valid_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [4:0]   rd_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W,
    output logic [31:0]  stallCount
);

    exmem_t     exmem_d, exmem_q;
    memwb_t     memwb_d, memwb_q;
    mem_state_t state_d, state_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic       load_done;

    // EX -> MEM boundary
    always_comb begin
        exmem_d            = '0;
        exmem_d.valid      = valid_E;
        exmem_d.mem_read   = MemRead_E;
        exmem_d.mem_write  = MemWrite_E;
        exmem_d.branch     = Branch_E;
        exmem_d.reg_write  = RegWrite_E;
        exmem_d.mem_to_reg = MemtoReg_E;
        exmem_d.rd         = rd_E;
        exmem_d.zero       = zero_E;
        exmem_d.pc_branch  = N_DEFAULT'(PCBranch_E);
        exmem_d.alu_result = N_DEFAULT'(aluResult_E);
        exmem_d.write_data = N_DEFAULT'(writeData_E);
    end

    pipe_reg #(.W($bits(exmem_t))) u_exmem (
        .clk_i (clk),
        .clr_i (reset),
        .en_i  (~stall_M),
        .d_i   (exmem_d),
        .q_o   (exmem_q)
    );

    assign dm_req   = (state_q == ACCESS);
    assign dm_we    = exmem_q.mem_write;
    assign dm_addr  = N'(exmem_q.alu_result);
    assign dm_wdata = N'(exmem_q.write_data);
    assign stall_M  = dm_req & ~dm_ready;

    // A set write bit wins over read, so dual-flagged ops never update readData.
    assign load_done = dm_req & dm_ready & exmem_q.mem_read & ~exmem_q.mem_write;

    assign PCSrc_M    = exmem_q.valid & exmem_q.branch & exmem_q.zero;
    assign PCBranch_M = N'(exmem_q.pc_branch);

    // Stay in ACCESS while waiting, or hand off directly to a newly loaded memory op.
    assign state_d = (stall_M || is_mem_op(valid_E, MemRead_E, MemWrite_E)) ? ACCESS : IDLE;

    assign stall_cnt_d = (stall_M && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                    : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // MEM -> WB boundary
    always_comb begin
        memwb_d = memwb_q;
        if (stall_M) begin
            memwb_d.valid     = 1'b0;
            memwb_d.reg_write = 1'b0;
        end else begin
            memwb_d.valid      = exmem_q.valid;
            memwb_d.reg_write  = exmem_q.reg_write & exmem_q.valid;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.rd         = exmem_q.rd;
            memwb_d.alu_result = exmem_q.alu_result;
            if (load_done) begin
                memwb_d.read_data = N_DEFAULT'(dm_rdata);
            end
        end
    end

    pipe_reg #(.W($bits(memwb_t))) u_memwb (
        .clk_i (clk),
        .clr_i (reset),
        .en_i  (1'b1),
        .d_i   (memwb_d),
        .q_o   (memwb_q)
    );

    assign valid_W     = memwb_q.valid;
    assign RegWrite_W  = memwb_q.reg_write;
    assign MemtoReg_W  = memwb_q.mem_to_reg;
    assign rd_W        = memwb_q.rd;
    assign aluResult_W = N'(memwb_q.alu_result);
    assign readData_W  = N'(memwb_q.read_data);
    assign stallCount  = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed table, handshake sequences, randomized model check.
module tb_ex_mem_stage;

    logic        clk;
    logic        reset;
    logic        valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E;
    logic [4:0]  rd_E;
    logic        zero_E;
    logic [63:0] PCBranch_E, aluResult_E, writeData_E;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ready;
    logic        stall_M, PCSrc_M;
    logic [63:0] PCBranch_M;
    logic        valid_W, RegWrite_W, MemtoReg_W;
    logic [4:0]  rd_W;
    logic [63:0] aluResult_W, readData_W;
    logic [31:0] stallCount;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.N(64)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E),
        .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .Branch_E(Branch_E),
        .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .rd_E(rd_E), .zero_E(zero_E),
        .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall_M(stall_M), .PCSrc_M(PCSrc_M),
        .PCBranch_M(PCBranch_M), .valid_W(valid_W), .RegWrite_W(RegWrite_W),
        .MemtoReg_W(MemtoReg_W), .rd_W(rd_W), .aluResult_W(aluResult_W),
        .readData_W(readData_W), .stallCount(stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld, rdn, wrn, br, rw, m2r;
        logic [4:0]  rd;
        logic        zero;
        logic [63:0] pcb, alu, wd;
    } ein_t;

    typedef struct {
        ein_t        e;
        logic [63:0] rdata;
        logic        x_req, x_we, x_pcsrc;
        logic [63:0] x_pcb;
        logic        x_vldw, x_rw, x_m2r;
        logic [63:0] x_rdw;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_e(input ein_t e);
        valid_E     = e.vld;
        MemRead_E   = e.rdn;
        MemWrite_E  = e.wrn;
        Branch_E    = e.br;
        RegWrite_E  = e.rw;
        MemtoReg_E  = e.m2r;
        rd_E        = e.rd;
        zero_E      = e.zero;
        PCBranch_E  = e.pcb;
        aluResult_E = e.alu;
        writeData_E = e.wd;
    endtask

    function automatic ein_t mk_load(input logic [63:0] addr, input logic [4:0] rd);
        ein_t e;
        e     = '0;
        e.vld = 1'b1; e.rdn = 1'b1; e.rw = 1'b1; e.m2r = 1'b1;
        e.rd  = rd;   e.alu = addr;
        return e;
    endfunction

    function automatic ein_t rand_e();
        ein_t e;
        int   k;
        e      = '0;
        k      = $urandom_range(0, 4);
        e.vld  = ($urandom_range(0, 3) != 0);
        e.rd   = 5'($urandom);
        e.zero = 1'($urandom);
        e.pcb  = {$urandom, $urandom};
        e.alu  = {$urandom, $urandom};
        e.wd   = {$urandom, $urandom};
        case (k)
            0: e.rw = 1'($urandom);
            1: begin e.rdn = 1'b1; e.rw = 1'b1; e.m2r = 1'b1; end
            2: e.wrn = 1'b1;
            3: e.br = 1'b1;
            default: begin e.rdn = 1'b1; e.wrn = 1'b1; end
        endcase
        if (!e.vld) begin
            e.rdn = 1'($urandom); e.wrn = 1'($urandom); e.br  = 1'($urandom);
            e.rw  = 1'($urandom); e.m2r = 1'($urandom);
        end
        return e;
    endfunction

    // Reference model state
    ein_t        m;
    logic        m_busy;
    logic [63:0] last_rd;
    int unsigned scount;
    logic        xw_vld, xw_rw, xw_m2r;
    logic [4:0]  xw_rd;
    logic [63:0] xw_alu;

    ein_t idle_e;
    ein_t cur;
    logic stall_x;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_e = '0;

        vecs[0] = '{ein_t'{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,5'd5,1'b0,64'h0,64'h1234,64'h55},
                    64'hBAD, 1'b0,1'b0,1'b0,64'h0, 1'b1,1'b1,1'b0,64'h0};
        vecs[1] = '{ein_t'{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,1'b1,64'h4,64'h10,64'h0},
                    64'h0, 1'b0,1'b0,1'b1,64'h4, 1'b1,1'b0,1'b0,64'h0};
        vecs[2] = '{ein_t'{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,1'b0,64'h8,64'h10,64'h0},
                    64'h0, 1'b0,1'b0,1'b0,64'h8, 1'b1,1'b0,1'b0,64'h0};
        vecs[3] = '{ein_t'{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,64'h0,64'h8,64'hFFFF_FFFF_FFFF_FFFE},
                    64'h77, 1'b1,1'b1,1'b0,64'h0, 1'b1,1'b0,1'b0,64'h0};
        vecs[4] = '{ein_t'{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,5'd7,1'b0,64'h0,64'h40,64'h0},
                    64'hCAFE, 1'b1,1'b0,1'b0,64'h0, 1'b1,1'b1,1'b1,64'hCAFE};
        vecs[5] = '{ein_t'{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,5'd31,1'b1,64'hC,64'h10,64'h3},
                    64'h99, 1'b0,1'b0,1'b0,64'hC, 1'b0,1'b0,1'b1,64'hCAFE};
        vecs[6] = '{ein_t'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd2,1'b0,64'h0,64'h20,64'h11},
                    64'h1111, 1'b1,1'b1,1'b0,64'h0, 1'b1,1'b0,1'b0,64'hCAFE};

        // Reset held two cycles with every input high
        reset = 1'b1;
        apply_e('1);
        dm_ready = 1'b1;
        dm_rdata = '1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_dm_req",  64'(dm_req),     64'h0);
            chk("rst_stall",   64'(stall_M),    64'h0);
            chk("rst_pcsrc",   64'(PCSrc_M),    64'h0);
            chk("rst_valid_w", 64'(valid_W),    64'h0);
            chk("rst_scount",  64'(stallCount), 64'h0);
        end
        reset = 1'b0;
        apply_e(idle_e);
        dm_ready = 1'b0;
        dm_rdata = '0;

        // Single-instruction vectors against a zero-wait memory
        for (int i = 0; i < 7; i++) begin
            apply_e(vecs[i].e);
            dm_ready = 1'b1;
            dm_rdata = vecs[i].rdata;
            @(posedge clk); #1;
            chk($sformatf("v%0d_dm_req", i), 64'(dm_req), 64'(vecs[i].x_req));
            chk($sformatf("v%0d_stall", i), 64'(stall_M), 64'h0);
            chk($sformatf("v%0d_pcsrc", i), 64'(PCSrc_M), 64'(vecs[i].x_pcsrc));
            chk($sformatf("v%0d_pcbranch", i), PCBranch_M, vecs[i].x_pcb);
            if (vecs[i].x_req) begin
                chk($sformatf("v%0d_dm_we", i), 64'(dm_we), 64'(vecs[i].x_we));
                chk($sformatf("v%0d_dm_addr", i), dm_addr, vecs[i].e.alu);
                chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].e.wd);
            end
            apply_e(idle_e);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_w", i), 64'(valid_W), 64'(vecs[i].x_vldw));
            chk($sformatf("v%0d_regwrite_w", i), 64'(RegWrite_W), 64'(vecs[i].x_rw));
            chk($sformatf("v%0d_readdata_w", i), readData_W, vecs[i].x_rdw);
            if (vecs[i].x_vldw) begin
                chk($sformatf("v%0d_memtoreg_w", i), 64'(MemtoReg_W), 64'(vecs[i].x_m2r));
                chk($sformatf("v%0d_rd_w", i), 64'(rd_W), 64'(vecs[i].e.rd));
                chk($sformatf("v%0d_alu_w", i), aluResult_W, vecs[i].e.alu);
            end
        end
        chk("table_scount", 64'(stallCount), 64'h0);
        dm_ready = 1'b0;

        // Load with ready on the third request cycle
        apply_e(mk_load(64'h100, 5'd3));
        @(posedge clk); #1;
        apply_e(idle_e);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                dm_ready = 1'b1;
                dm_rdata = 64'hDEAD;
            end
            #1;
            chk($sformatf("ld_req_c%0d", c), 64'(dm_req), 64'h1);
            chk($sformatf("ld_addr_c%0d", c), dm_addr, 64'h100);
            chk($sformatf("ld_we_c%0d", c), 64'(dm_we), 64'h0);
            chk($sformatf("ld_stall_c%0d", c), 64'(stall_M), (c == 2) ? 64'h0 : 64'h1);
            @(posedge clk); #1;
            chk($sformatf("ld_valid_w_c%0d", c), 64'(valid_W), (c == 2) ? 64'h1 : 64'h0);
        end
        dm_ready = 1'b0;
        chk("ld_readdata", readData_W, 64'hDEAD);
        chk("ld_memtoreg", 64'(MemtoReg_W), 64'h1);
        chk("ld_rd", 64'(rd_W), 64'h3);
        chk("ld_regwrite", 64'(RegWrite_W), 64'h1);
        chk("ld_scount", 64'(stallCount), 64'h2);
        #1 chk("ld_req_done", 64'(dm_req), 64'h0);

        // Two back-to-back loads, one wait cycle each
        apply_e(mk_load(64'h200, 5'd4));
        @(posedge clk); #1;
        apply_e(mk_load(64'h300, 5'd6));
        #1;
        chk("b2b_req0", 64'(dm_req), 64'h1);
        chk("b2b_addr0", dm_addr, 64'h200);
        chk("b2b_stall0", 64'(stall_M), 64'h1);
        @(posedge clk); #1;
        chk("b2b_bubble0", 64'(valid_W), 64'h0);
        dm_ready = 1'b1;
        dm_rdata = 64'hA1;
        #1;
        chk("b2b_addr0_rdy", dm_addr, 64'h200);
        chk("b2b_stall0_rdy", 64'(stall_M), 64'h0);
        @(posedge clk); #1;
        apply_e(idle_e);
        dm_ready = 1'b0;
        chk("b2b_valid_w1", 64'(valid_W), 64'h1);
        chk("b2b_rdata1", readData_W, 64'hA1);
        chk("b2b_rd1", 64'(rd_W), 64'h4);
        #1;
        chk("b2b_req1", 64'(dm_req), 64'h1);
        chk("b2b_addr1", dm_addr, 64'h300);
        chk("b2b_stall1", 64'(stall_M), 64'h1);
        @(posedge clk); #1;
        chk("b2b_bubble1", 64'(valid_W), 64'h0);
        dm_ready = 1'b1;
        dm_rdata = 64'hB2;
        @(posedge clk); #1;
        dm_ready = 1'b0;
        chk("b2b_valid_w2", 64'(valid_W), 64'h1);
        chk("b2b_rdata2", readData_W, 64'hB2);
        chk("b2b_rd2", 64'(rd_W), 64'h6);
        chk("b2b_req_done", 64'(dm_req), 64'h0);
        chk("b2b_scount", 64'(stallCount), 64'h4);

        // Reset in the middle of a waiting load
        apply_e(mk_load(64'h400, 5'd9));
        @(posedge clk); #1;
        apply_e(idle_e);
        #1;
        chk("rstld_req_before", 64'(dm_req), 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dm_ready = 1'b1;
        dm_rdata = 64'h55;
        #1;
        chk("rstld_req", 64'(dm_req), 64'h0);
        chk("rstld_stall", 64'(stall_M), 64'h0);
        chk("rstld_scount", 64'(stallCount), 64'h0);
        @(posedge clk); #1;
        dm_ready = 1'b0;
        chk("rstld_valid_w", 64'(valid_W), 64'h0);
        chk("rstld_readdata", readData_W, 64'h0);

        // Randomized traffic against the reference model
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m = '0; m_busy = 1'b0; last_rd = '0; scount = 0;
        xw_vld = 1'b0; xw_rw = 1'b0; xw_m2r = 1'b0; xw_rd = '0; xw_alu = '0;
        for (int c = 0; c < 600; c++) begin
            cur = rand_e();
            apply_e(cur);
            dm_ready = ($urandom_range(0, 2) != 0);
            dm_rdata = {$urandom, $urandom};
            #1;
            stall_x = m_busy && !dm_ready;
            chk("rnd_dm_req", 64'(dm_req), 64'(m_busy));
            chk("rnd_stall", 64'(stall_M), 64'(stall_x));
            chk("rnd_pcsrc", 64'(PCSrc_M), 64'(m.vld & m.br & m.zero));
            chk("rnd_pcbranch", PCBranch_M, m.pcb);
            if (m_busy) begin
                chk("rnd_dm_we", 64'(dm_we), 64'(m.wrn));
                chk("rnd_dm_addr", dm_addr, m.alu);
                chk("rnd_dm_wdata", dm_wdata, m.wd);
            end
            if (stall_x) begin
                xw_vld = 1'b0;
                xw_rw  = 1'b0;
                scount++;
            end else begin
                xw_vld = m.vld;
                xw_rw  = m.rw & m.vld;
                xw_m2r = m.m2r;
                xw_rd  = m.rd;
                xw_alu = m.alu;
                if (m_busy && m.rdn && !m.wrn) last_rd = dm_rdata;
                m      = cur;
                m_busy = cur.vld && (cur.rdn || cur.wrn);
            end
            @(posedge clk); #1;
            chk("rnd_valid_w", 64'(valid_W), 64'(xw_vld));
            chk("rnd_regwrite_w", 64'(RegWrite_W), 64'(xw_rw));
            chk("rnd_memtoreg_w", 64'(MemtoReg_W), 64'(xw_m2r));
            chk("rnd_rd_w", 64'(rd_W), 64'(xw_rd));
            chk("rnd_alu_w", aluResult_W, xw_alu);
            chk("rnd_readdata_w", readData_W, last_rd);
            chk("rnd_scount", 64'(stallCount), 64'(scount));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
